// File: rtl/board_renderer_pkg.sv
// Package enum_type: cell-kind and colour constants shared by the renderer
// and the tetris core.
//   KIND_EMPTY      : cell/slot kind meaning "nothing here"
//   PAL_0 .. PAL_7  : 12-bit {R,G,B} colour for each cell kind
//   RGB_*           : fixed colours (blank, empty swatch, grid, backdrop)
package enum_type;

    localparam logic [2:0]  KIND_EMPTY       = 3'd0;

    localparam logic [11:0] PAL_0            = 12'h000;
    localparam logic [11:0] PAL_1            = 12'h09D;
    localparam logic [11:0] PAL_2            = 12'h04F;
    localparam logic [11:0] PAL_3            = 12'hD90;
    localparam logic [11:0] PAL_4            = 12'hFF0;
    localparam logic [11:0] PAL_5            = 12'h0F3;
    localparam logic [11:0] PAL_6            = 12'h80C;
    localparam logic [11:0] PAL_7            = 12'hF00;

    localparam logic [11:0] RGB_BLANK        = 12'h000;
    localparam logic [11:0] RGB_SWATCH_EMPTY = 12'h222;
    localparam logic [11:0] RGB_GRID         = 12'h333;
    localparam logic [11:0] RGB_BACKDROP     = 12'h111;

endpackage

// File: rtl/board_renderer_if.sv
// Cell query bus between the renderer (master) and the tetris core (slave).
//   cell_x / cell_y : playfield cell being queried
//   cell_kind       : kind of that cell, valid in the clk after the query
//   hold_kind       : kind in the hold slot
//   next_kind       : four upcoming kinds, [2:0] is the first
interface board_renderer_if;
    logic [3:0]  cell_x;
    logic [4:0]  cell_y;
    logic [2:0]  cell_kind;
    logic [2:0]  hold_kind;
    logic [11:0] next_kind;

    modport master (output cell_x, cell_y, input cell_kind, hold_kind, next_kind);
    modport slave  (input cell_x, cell_y, output cell_kind, hold_kind, next_kind);
endinterface

// File: rtl/board_renderer_kind_palette.sv
// kind_palette: combinational map from a cell kind to 12-bit RGB.
//   kind      in  3   cell or slot kind
//   is_swatch in  1   kind comes from a hold/next swatch (empty draws grey)
//   rgb       out 12  {R,G,B}
module kind_palette
    import enum_type::*;
(
    input  logic [2:0]  kind,
    input  logic        is_swatch,
    output logic [11:0] rgb
);

    always_comb begin
        rgb = PAL_0;
        case (kind)
            3'd0: rgb = is_swatch ? RGB_SWATCH_EMPTY : PAL_0;
            3'd1: rgb = PAL_1;
            3'd2: rgb = PAL_2;
            3'd3: rgb = PAL_3;
            3'd4: rgb = PAL_4;
            3'd5: rgb = PAL_5;
            3'd6: rgb = PAL_6;
            3'd7: rgb = PAL_7;
            default: rgb = PAL_0;
        endcase
    end

endmodule

// File: rtl/board_renderer.sv
// board_renderer: pixel pipeline from the VGA sync generator to the pins.
// Tracks the playfield cell with counters (no divide), queries the tetris
// core, colours board cells plus the hold/next swatches, and delays the syncs
// so they stay aligned with rgb (3 clks: S0 flags, S1 query, S2 colour).
//   clk, reset (sync, active-high)
//   p_tick, visible, hsync_in, vsync_in, pixel_x, pixel_y  : from sync gen
//   tq (board_renderer_if.master)                          : cell query bus
//   rgb, hsync_out, vsync_out                              : to pins
// Build option: define GRID_LINES_EN to draw grid lines (sub_x==0 or
// sub_y==0) inside the board.
module board_renderer
    import enum_type::*;
#(
    parameter int BOARD_X0 = 220,
    parameter int BOARD_Y0 = 40,
    parameter int CELL_PX  = 20,
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int HOLD_X0  = 140,
    parameter int NEXT_X0  = 460
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_tick,
    input  logic                     visible,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic [9:0]               pixel_x,
    input  logic [9:0]               pixel_y,
    board_renderer_if.master         tq,
    output logic [11:0]              rgb,
    output logic                     hsync_out,
    output logic                     vsync_out
);

    localparam int SW_PX      = 60;
    localparam int NEXT_PITCH = 70;

    localparam logic [9:0] X0     = 10'(BOARD_X0);
    localparam logic [9:0] X1     = 10'(BOARD_X0 + COLS * CELL_PX);
    localparam logic [9:0] Y0     = 10'(BOARD_Y0);
    localparam logic [9:0] Y1     = 10'(BOARD_Y0 + ROWS * CELL_PX);
    localparam logic [9:0] Y0_M1  = 10'(BOARD_Y0 - 1);
    localparam logic [9:0] HX0    = 10'(HOLD_X0);
    localparam logic [9:0] HX1    = 10'(HOLD_X0 + SW_PX);
    localparam logic [9:0] SY1    = 10'(BOARD_Y0 + SW_PX);
    localparam logic [9:0] NX0    = 10'(NEXT_X0);
    localparam logic [9:0] NX1    = 10'(NEXT_X0 + SW_PX);
    localparam logic [9:0] X_LAST = 10'd639;
    localparam logic [9:0] Y_LAST = 10'd479;
    localparam logic [4:0] SUB_LAST = 5'(CELL_PX - 1);
    localparam logic [3:0] COL_LAST = 4'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    // cell position counters (describe the pixel held in S0)
    logic [4:0] sub_x_d, sub_x_q, sub_y_d, sub_y_q, row_d, row_q;
    logic [3:0] col_d, col_q;

    // S0
    logic       in_x, in_y, in_board, in_hold, in_next;
    logic [1:0] next_idx;
    logic       s0_vis_q, s0_hs_q, s0_vs_q, s0_board_q, s0_hold_q, s0_next_q;
    logic [1:0] s0_nidx_q;

    // S1
    logic [3:0] cell_x_d, cell_x_q;
    logic [4:0] cell_y_d, cell_y_q;
    logic [2:0] s1_sw_kind_d, s1_sw_kind_q;
    logic       s1_vis_q, s1_hs_q, s1_vs_q, s1_board_q, s1_sw_q;

    // S2
    logic [11:0] pal_rgb, rgb_d, rgb_q;
    logic        hs_out_q, vs_out_q;

    assign in_x     = (pixel_x >= X0) && (pixel_x < X1);
    assign in_y     = (pixel_y >= Y0) && (pixel_y < Y1);
    assign in_board = in_x && in_y;
    assign in_hold  = (pixel_x >= HX0) && (pixel_x < HX1) && (pixel_y >= Y0) && (pixel_y < SY1);

    always_comb begin
        in_next  = 1'b0;
        next_idx = 2'd0;
        if ((pixel_x >= NX0) && (pixel_x < NX1)) begin
            for (int i = 0; i < 4; i++) begin
                if ((pixel_y >= 10'(BOARD_Y0 + NEXT_PITCH * i)) &&
                    (pixel_y <  10'(BOARD_Y0 + NEXT_PITCH * i + SW_PX))) begin
                    in_next  = 1'b1;
                    next_idx = 2'(i);
                end
            end
        end
    end

    // Column counter restarts at the board's left edge; the row counter
    // steps once per line at x=639, so it already points at the next line.
    // Both saturate so the query never leaves the playfield.
    always_comb begin
        sub_x_d = sub_x_q;
        col_d   = col_q;
        sub_y_d = sub_y_q;
        row_d   = row_q;
        if (p_tick) begin
            if (pixel_x == X0) begin
                sub_x_d = '0;
                col_d   = '0;
            end else if (in_x) begin
                if (sub_x_q == SUB_LAST) begin
                    sub_x_d = '0;
                    if (col_q != COL_LAST) col_d = col_q + 4'd1;
                end else begin
                    sub_x_d = sub_x_q + 5'd1;
                end
            end
            if (pixel_x == X_LAST) begin
                if ((pixel_y == Y_LAST) || (pixel_y == Y0_M1)) begin
                    sub_y_d = '0;
                    row_d   = '0;
                end else if (in_y) begin
                    if (sub_y_q == SUB_LAST) begin
                        sub_y_d = '0;
                        if (row_q != ROW_LAST) row_d = row_q + 5'd1;
                    end else begin
                        sub_y_d = sub_y_q + 5'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        cell_x_d     = s0_board_q ? col_q : cell_x_q;
        cell_y_d     = s0_board_q ? row_q : cell_y_q;
        s1_sw_kind_d = tq.hold_kind;
        if (!s0_hold_q) begin
            case (s0_nidx_q)
                2'd0:    s1_sw_kind_d = tq.next_kind[2:0];
                2'd1:    s1_sw_kind_d = tq.next_kind[5:3];
                2'd2:    s1_sw_kind_d = tq.next_kind[8:6];
                default: s1_sw_kind_d = tq.next_kind[11:9];
            endcase
        end
    end

`ifdef GRID_LINES_EN
    logic s1_grid_d, s1_grid_q;

    always_comb begin
        s1_grid_d = (sub_x_q == '0) || (sub_y_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) s1_grid_q <= 1'b0;
        else       s1_grid_q <= s1_grid_d;
    end
`endif

    kind_palette u_kind_palette (
        .kind      (s1_board_q ? tq.cell_kind : s1_sw_kind_q),
        .is_swatch (!s1_board_q),
        .rgb       (pal_rgb)
    );

    always_comb begin
        rgb_d = RGB_BACKDROP;
        if (!s1_vis_q) begin
            rgb_d = RGB_BLANK;
        end else if (s1_board_q) begin
`ifdef GRID_LINES_EN
            rgb_d = s1_grid_q ? RGB_GRID : pal_rgb;
`else
            rgb_d = pal_rgb;
`endif
        end else if (s1_sw_q) begin
            rgb_d = pal_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_x_q <= '0; col_q <= '0; sub_y_q <= '0; row_q <= '0;
            s0_vis_q <= 1'b0; s0_hs_q <= 1'b1; s0_vs_q <= 1'b1;
            s0_board_q <= 1'b0; s0_hold_q <= 1'b0; s0_next_q <= 1'b0; s0_nidx_q <= '0;
            cell_x_q <= '0; cell_y_q <= '0; s1_sw_kind_q <= '0;
            s1_vis_q <= 1'b0; s1_hs_q <= 1'b1; s1_vs_q <= 1'b1;
            s1_board_q <= 1'b0; s1_sw_q <= 1'b0;
            rgb_q <= RGB_BLANK; hs_out_q <= 1'b1; vs_out_q <= 1'b1;
        end else begin
            sub_x_q <= sub_x_d; col_q <= col_d; sub_y_q <= sub_y_d; row_q <= row_d;
            s0_vis_q <= visible; s0_hs_q <= hsync_in; s0_vs_q <= vsync_in;
            s0_board_q <= in_board; s0_hold_q <= in_hold; s0_next_q <= in_next; s0_nidx_q <= next_idx;
            cell_x_q <= cell_x_d; cell_y_q <= cell_y_d; s1_sw_kind_q <= s1_sw_kind_d;
            s1_vis_q <= s0_vis_q; s1_hs_q <= s0_hs_q; s1_vs_q <= s0_vs_q;
            s1_board_q <= s0_board_q; s1_sw_q <= s0_hold_q || s0_next_q;
            rgb_q <= rgb_d; hs_out_q <= s1_hs_q; vs_out_q <= s1_vs_q;
        end
    end

    assign tq.cell_x = cell_x_q;
    assign tq.cell_y = cell_y_q;
    assign rgb       = rgb_q;
    assign hsync_out = hs_out_q;
    assign vsync_out = vs_out_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: drives a partial raster, stubs the
// tetris core with cell_kind = cell_x[2:0], and compares against
// hand-computed colours and cell coordinates.
module tb_board_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic        visible = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;
    int          n_checks = 0;
    int          n_fail = 0;

    board_renderer_if tq ();

    assign tq.cell_kind = tq.cell_x[2:0];

    board_renderer dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .visible   (visible),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .tq        (tq.master),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    always #10 clk = ~clk;

`ifdef GRID_LINES_EN
    localparam logic [11:0] GRID_OR_K0 = 12'h333;
    localparam logic [11:0] GRID_OR_K1 = 12'h333;
`else
    localparam logic [11:0] GRID_OR_K0 = 12'h000;
    localparam logic [11:0] GRID_OR_K1 = 12'h09D;
`endif

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int x, input int y);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        p_tick  = 1'b1;
        step();
        p_tick  = 1'b0;
    endtask

    task automatic sweep(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) px(x, y);
    endtask

    task automatic line_ends(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) px(639, y);
    endtask

    function automatic logic [11:0] cell_of(input logic [3:0] cx, input logic [4:0] cy);
        return {3'b000, cy, cx};
    endfunction

    initial begin
        tq.hold_kind = 3'd5;
        tq.next_kind = 12'o7421;
        repeat (3) step();
        reset = 1'b0;

        // reset mid-line, with syncs low so a missed reset shows
        line_ends(39, 39);
        sweep(40, 220, 260);
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        reset = 1'b1;
        repeat (5) step();
        check_val("rst_rgb", rgb, 12'h000);
        check_val("rst_hs", {11'b0, hsync_out}, 12'h001);
        check_val("rst_vs", {11'b0, vsync_out}, 12'h001);
        check_val("rst_cell", cell_of(tq.cell_x, tq.cell_y), 12'h000);
        reset = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) step();

        // top-left cell, grid corner
        line_ends(39, 39);
        px(220, 40);
        step(); check_val("c220_40", cell_of(tq.cell_x, tq.cell_y), cell_of(4'd0, 5'd0));
        step(); check_val("r220_40", rgb, GRID_OR_K0);
        line_ends(40, 44);

        // grid column edge vs cell interior
        sweep(45, 220, 240);
        step(); step(); check_val("g240_45", rgb, GRID_OR_K1);
        sweep(45, 241, 245);
        step(); step(); check_val("g245_45", rgb, 12'h09D);
        line_ends(45, 49);

        // hold swatch, latency, first next swatch
        px(150, 50);
        step(); step(); check_val("hold5", rgb, 12'h0F3);
        tq.hold_kind = 3'd0;
        px(151, 50);
        step(); step(); check_val("hold0", rgb, 12'h222);
        tq.hold_kind = 3'd5;
        sweep(50, 220, 279);
        px(280, 50);
        step(); check_val("lat2", rgb, 12'h04F);
        step(); check_val("lat3", rgb, 12'hD90);
        px(470, 50);
        step(); step(); check_val("next0", rgb, 12'h09D);
        line_ends(50, 58);

        sweep(59, 220, 239);
        step(); check_val("c239_59", cell_of(tq.cell_x, tq.cell_y), cell_of(4'd0, 5'd0));
        line_ends(59, 59);

        sweep(60, 220, 240);
        step(); check_val("c240_60", cell_of(tq.cell_x, tq.cell_y), cell_of(4'd1, 5'd1));
        sweep(60, 241, 245);
        step(); step(); check_val("g245_60", rgb, GRID_OR_K1);
        line_ends(60, 119);

        px(470, 120);
        step(); step(); check_val("next1", rgb, 12'h04F);
        line_ends(120, 189);
        px(470, 190);
        step(); step(); check_val("next2", rgb, 12'hFF0);
        line_ends(190, 259);
        px(470, 260);
        step(); step(); check_val("next3", rgb, 12'hF00);
        line_ends(260, 438);

        // bottom-right cell and the right boundary
        sweep(439, 220, 419);
        step(); check_val("c419_439", cell_of(tq.cell_x, tq.cell_y), cell_of(4'd9, 5'd19));
        step(); check_val("r419_439", rgb, 12'h09D);
        px(420, 439);
        step(); check_val("c420_439", cell_of(tq.cell_x, tq.cell_y), cell_of(4'd9, 5'd19));
        step(); check_val("r420_439", rgb, 12'h111);

        visible = 1'b0;
        px(300, 439);
        step(); step(); check_val("novis", rgb, 12'h000);
        visible = 1'b1;

        // 2-clk hsync pulse
        hsync_in = 1'b0;
        px(500, 439);
        px(501, 439);
        hsync_in = 1'b1;
        check_val("hs_pre", {11'b0, hsync_out}, 12'h001);
        step(); check_val("hs_d3", {11'b0, hsync_out}, 12'h000);
        step(); check_val("hs_w2", {11'b0, hsync_out}, 12'h000);
        step(); check_val("hs_end", {11'b0, hsync_out}, 12'h001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
